// File: rtl/mul_rs_pkg.sv
// Shared types and helpers for the multiplier reservation station.
// Optional feature macro used by the station: MUL_RS_WAKEUP_BYPASS_EN.
package mul_rs_pkg;

    localparam int RS_ROB_IX      = 2;
    localparam int RS_NUM_ENTRIES = 4;
    localparam int RS_DATA_W      = 32;

    typedef logic [RS_ROB_IX:0]   tag_t;
    typedef logic [RS_DATA_W-1:0] data_t;

    // One station slot: occupancy, operand readiness, producer tags, values, destination
    typedef struct packed {
        logic  busy;
        logic  rdy1;
        logic  rdy2;
        tag_t  q1;
        tag_t  q2;
        data_t v1;
        data_t v2;
        tag_t  rob_ix;
    } rs_entry_t;

    // Result of a lowest-set-bit search over a vector of up to 32 bits
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } sel_t;

    function automatic sel_t first_set(input logic [31:0] vec);
        sel_t r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_priority_select.sv
// Fixed-priority picker: lowest-index set request wins.
// Produces a one-hot grant, the binary index and a found flag.
module rs_priority_select
    import mul_rs_pkg::*;
#(
    parameter int N  = RS_NUM_ENTRIES,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [31:0] vec;
    sel_t        sel;

    // Lowest set request becomes the grant
    always_comb begin
        vec        = '0;
        vec[N-1:0] = req;
        sel        = first_set(vec);
        grant      = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = sel.found && (sel.idx == 5'(i));
        end
        idx   = sel.idx[IW-1:0];
        found = sel.found;
    end

endmodule

// File: rtl/mul_reservation_station.sv
// Tomasulo reservation station in front of the 6-cycle multiplier.
// Holds dispatched MUL ops, snoops the CDB for missing operands and issues
// the lowest-index ready op whenever the multiplier reports ready.
// Optional feature: define MUL_RS_WAKEUP_BYPASS_EN to let an op whose last
// missing operand arrives on the CDB issue in that same cycle.
//
// Issue handshake: issue_valid_out only rises while fu_ready_in is high, and a
// transfer happens on every clock edge where both are high; the issued slot is
// freed at that edge. The station never holds issue_valid_out waiting for ready.
module mul_reservation_station
    import mul_rs_pkg::*;
#(
    parameter int ROB_IX      = RS_ROB_IX,
    parameter int NUM_ENTRIES = RS_NUM_ENTRIES
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              flush_in,
    input  logic              disp_valid_in,
    input  logic [ROB_IX:0]   disp_rob_ix_in,
    input  logic              disp_v1_rdy_in,
    input  logic [31:0]       disp_v1_in,
    input  logic [ROB_IX:0]   disp_q1_in,
    input  logic              disp_v2_rdy_in,
    input  logic [31:0]       disp_v2_in,
    input  logic [ROB_IX:0]   disp_q2_in,
    output logic              full_out,
    output logic              empty_out,
    input  logic              cdb_valid_in,
    input  logic [ROB_IX:0]   cdb_rob_ix_in,
    input  logic [31:0]       cdb_data_in,
    input  logic              fu_ready_in,
    output logic              issue_valid_out,
    output logic [31:0]       rval1_out,
    output logic [31:0]       rval2_out,
    output logic [ROB_IX:0]   rob_ix_out
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    rs_entry_t entries     [NUM_ENTRIES];
    rs_entry_t entries_nxt [NUM_ENTRIES];
    rs_entry_t new_entry;

    logic [NUM_ENTRIES-1:0] busy_vec;
    logic [NUM_ENTRIES-1:0] hit1;
    logic [NUM_ENTRIES-1:0] hit2;
    logic [NUM_ENTRIES-1:0] iss_req;
    logic [NUM_ENTRIES-1:0] free_grant;
    logic [NUM_ENTRIES-1:0] iss_grant;
    logic [IW-1:0]          free_idx;
    logic [IW-1:0]          iss_idx;
    logic                   free_found;
    logic                   iss_found;
    logic                   disp_accept;
    logic                   issue_fire;
    logic                   disp_hit1;
    logic                   disp_hit2;

    // Per-slot CDB tag matches for operands still waiting, and issue eligibility
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            busy_vec[i] = entries[i].busy;
            hit1[i] = cdb_valid_in && entries[i].busy && !entries[i].rdy1 &&
                      (entries[i].q1 == cdb_rob_ix_in);
            hit2[i] = cdb_valid_in && entries[i].busy && !entries[i].rdy2 &&
                      (entries[i].q2 == cdb_rob_ix_in);
`ifdef MUL_RS_WAKEUP_BYPASS_EN
            iss_req[i] = entries[i].busy &&
                         (entries[i].rdy1 || hit1[i]) &&
                         (entries[i].rdy2 || hit2[i]);
`else
            iss_req[i] = entries[i].busy && entries[i].rdy1 && entries[i].rdy2;
`endif
        end
    end

    rs_priority_select #(.N(NUM_ENTRIES), .IW(IW)) u_free_pick (
        .req   (~busy_vec),
        .grant (free_grant),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_select #(.N(NUM_ENTRIES), .IW(IW)) u_issue_pick (
        .req   (iss_req),
        .grant (iss_grant),
        .idx   (iss_idx),
        .found (iss_found)
    );

    // Occupancy flags depend on registered busy bits only; no grant means no free slot
    always_comb begin
        full_out  = ~|free_grant;
        empty_out = ~|busy_vec;
    end

    // Issue port: candidate slot fields, zero when nothing is ready
    always_comb begin
        issue_valid_out = fu_ready_in && iss_found;
        rval1_out       = '0;
        rval2_out       = '0;
        rob_ix_out      = '0;
        if (iss_found) begin
            rval1_out  = entries[iss_idx].v1;
            rval2_out  = entries[iss_idx].v2;
            rob_ix_out = entries[iss_idx].rob_ix;
`ifdef MUL_RS_WAKEUP_BYPASS_EN
            if (hit1[iss_idx]) rval1_out = cdb_data_in;
            if (hit2[iss_idx]) rval2_out = cdb_data_in;
`endif
        end
    end

    // Build the incoming entry, capturing a same-cycle CDB result for a waiting operand
    always_comb begin
        disp_accept = disp_valid_in && free_found && !flush_in;
        issue_fire  = fu_ready_in && iss_found;
        disp_hit1   = cdb_valid_in && !disp_v1_rdy_in && (disp_q1_in == cdb_rob_ix_in);
        disp_hit2   = cdb_valid_in && !disp_v2_rdy_in && (disp_q2_in == cdb_rob_ix_in);

        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.rob_ix = disp_rob_ix_in;
        new_entry.q1     = disp_q1_in;
        new_entry.q2     = disp_q2_in;
        new_entry.rdy1   = disp_v1_rdy_in || disp_hit1;
        new_entry.rdy2   = disp_v2_rdy_in || disp_hit2;
        new_entry.v1     = disp_hit1 ? cdb_data_in : disp_v1_in;
        new_entry.v2     = disp_hit2 ? cdb_data_in : disp_v2_in;
    end

    // Next slot contents: flush wins, then issue frees, snoop wakes, dispatch fills
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries_nxt[i] = entries[i];
        end
        if (flush_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_nxt[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (issue_fire && iss_grant[i]) begin
                    entries_nxt[i].busy = 1'b0;
                end else begin
                    if (hit1[i]) begin
                        entries_nxt[i].rdy1 = 1'b1;
                        entries_nxt[i].v1   = cdb_data_in;
                    end
                    if (hit2[i]) begin
                        entries_nxt[i].rdy2 = 1'b1;
                        entries_nxt[i].v2   = cdb_data_in;
                    end
                end
            end
            // Free slot comes from registered busy bits, so a slot issued now stays unavailable
            if (disp_accept) begin
                entries_nxt[free_idx] = new_entry;
            end
        end
    end

    // Slot storage with asynchronous clear
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= entries_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_mul_reservation_station.sv
// Directed plus randomized checks of mul_reservation_station against a
// slot-list reference model of the station's rules.
module tb_mul_reservation_station;

`ifdef MUL_RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int N = 4;

    logic        clk_in, rst_n_in, flush_in;
    logic        disp_valid_in, disp_v1_rdy_in, disp_v2_rdy_in;
    logic [2:0]  disp_rob_ix_in, disp_q1_in, disp_q2_in;
    logic [31:0] disp_v1_in, disp_v2_in;
    logic        full_out, empty_out;
    logic        cdb_valid_in;
    logic [2:0]  cdb_rob_ix_in;
    logic [31:0] cdb_data_in;
    logic        fu_ready_in, issue_valid_out;
    logic [31:0] rval1_out, rval2_out;
    logic [2:0]  rob_ix_out;

    mul_reservation_station dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .flush_in        (flush_in),
        .disp_valid_in   (disp_valid_in),
        .disp_rob_ix_in  (disp_rob_ix_in),
        .disp_v1_rdy_in  (disp_v1_rdy_in),
        .disp_v1_in      (disp_v1_in),
        .disp_q1_in      (disp_q1_in),
        .disp_v2_rdy_in  (disp_v2_rdy_in),
        .disp_v2_in      (disp_v2_in),
        .disp_q2_in      (disp_q2_in),
        .full_out        (full_out),
        .empty_out       (empty_out),
        .cdb_valid_in    (cdb_valid_in),
        .cdb_rob_ix_in   (cdb_rob_ix_in),
        .cdb_data_in     (cdb_data_in),
        .fu_ready_in     (fu_ready_in),
        .issue_valid_out (issue_valid_out),
        .rval1_out       (rval1_out),
        .rval2_out       (rval2_out),
        .rob_ix_out      (rob_ix_out)
    );

    // Clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: list of slots in index order
    bit          mb [N];
    bit          mr1[N];
    bit          mr2[N];
    logic [2:0]  mq1[N];
    logic [2:0]  mq2[N];
    logic [2:0]  mrob[N];
    logic [31:0] mv1[N];
    logic [31:0] mv2[N];

    bit          e_full, e_empty, e_iv;
    logic [31:0] e_r1, e_r2;
    logic [2:0]  e_rob;
    int          e_slot;

    logic        obs_full, obs_empty, obs_iv;
    logic [31:0] obs_r1, obs_r2;
    logic [2:0]  obs_rob;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) mb[i] = 0;
    endfunction

    // Expected outputs from model state and current inputs
    function automatic void model_eval();
        int cnt;
        bit h1, h2;
        cnt = 0;
        e_slot = -1;
        e_r1 = 0; e_r2 = 0; e_rob = 0;
        for (int i = 0; i < N; i++) begin
            if (mb[i]) begin
                cnt++;
                h1 = cdb_valid_in && !mr1[i] && (mq1[i] == cdb_rob_ix_in);
                h2 = cdb_valid_in && !mr2[i] && (mq2[i] == cdb_rob_ix_in);
                if (e_slot < 0 && (mr1[i] || (BYP && h1)) && (mr2[i] || (BYP && h2))) begin
                    e_slot = i;
                    e_r1   = mr1[i] ? mv1[i] : cdb_data_in;
                    e_r2   = mr2[i] ? mv2[i] : cdb_data_in;
                    e_rob  = mrob[i];
                end
            end
        end
        e_full  = (cnt == N);
        e_empty = (cnt == 0);
        e_iv    = fu_ready_in && (e_slot >= 0);
    endfunction

    // Advance the model across one clock edge
    function automatic void model_step();
        int free_slot;
        if (flush_in) begin
            model_clear();
            return;
        end
        free_slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!mb[i]) free_slot = i;
        for (int i = 0; i < N; i++) begin
            if (e_iv && i == e_slot) begin
                mb[i] = 0;
            end else if (mb[i] && cdb_valid_in) begin
                if (!mr1[i] && mq1[i] == cdb_rob_ix_in) begin mr1[i] = 1; mv1[i] = cdb_data_in; end
                if (!mr2[i] && mq2[i] == cdb_rob_ix_in) begin mr2[i] = 1; mv2[i] = cdb_data_in; end
            end
        end
        if (disp_valid_in && free_slot >= 0) begin
            mb[free_slot]   = 1;
            mrob[free_slot] = disp_rob_ix_in;
            mq1[free_slot]  = disp_q1_in;
            mq2[free_slot]  = disp_q2_in;
            mr1[free_slot]  = disp_v1_rdy_in;
            mr2[free_slot]  = disp_v2_rdy_in;
            mv1[free_slot]  = disp_v1_in;
            mv2[free_slot]  = disp_v2_in;
            if (cdb_valid_in && !disp_v1_rdy_in && disp_q1_in == cdb_rob_ix_in) begin
                mr1[free_slot] = 1; mv1[free_slot] = cdb_data_in;
            end
            if (cdb_valid_in && !disp_v2_rdy_in && disp_q2_in == cdb_rob_ix_in) begin
                mr2[free_slot] = 1; mv2[free_slot] = cdb_data_in;
            end
        end
    endfunction

    // Driver tasks
    task automatic idle();
        disp_valid_in  = 0;
        disp_v1_rdy_in = 0; disp_v2_rdy_in = 0;
        disp_v1_in     = 0; disp_v2_in     = 0;
        disp_q1_in     = 0; disp_q2_in     = 0;
        disp_rob_ix_in = 0;
        cdb_valid_in   = 0; cdb_rob_ix_in  = 0; cdb_data_in = 0;
        flush_in       = 0;
    endtask

    task automatic disp(input bit r1, input logic [31:0] v1, input logic [2:0] q1,
                        input bit r2, input logic [31:0] v2, input logic [2:0] q2,
                        input logic [2:0] rob);
        disp_valid_in  = 1;
        disp_v1_rdy_in = r1; disp_v1_in = v1; disp_q1_in = q1;
        disp_v2_rdy_in = r2; disp_v2_in = v2; disp_q2_in = q2;
        disp_rob_ix_in = rob;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
        cdb_valid_in = 1; cdb_rob_ix_in = tag; cdb_data_in = data;
    endtask

    // One clock: compare at the falling edge, step model at the rising edge
    task automatic cycle();
        @(negedge clk_in);
        model_eval();
        obs_full = full_out; obs_empty = empty_out; obs_iv = issue_valid_out;
        obs_r1 = rval1_out; obs_r2 = rval2_out; obs_rob = rob_ix_out;
        chk("model_full",  32'(obs_full),  32'(e_full));
        chk("model_empty", 32'(obs_empty), 32'(e_empty));
        chk("model_issue", 32'(obs_iv),    32'(e_iv));
        chk("model_rval1", obs_r1,         e_r1);
        chk("model_rval2", obs_r2,         e_r2);
        chk("model_rob",   32'(obs_rob),   32'(e_rob));
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    initial begin
        idle();
        fu_ready_in = 0;
        rst_n_in    = 0;
        model_clear();
        #1;
        chk("rst0_empty", 32'(empty_out), 32'd1);
        chk("rst0_full",  32'(full_out),  32'd0);
        @(negedge clk_in);
        rst_n_in = 1;
        @(posedge clk_in);
        #1;

        // Reset mid-traffic with three busy slots
        fu_ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            disp(1, 32'(10 + i), 0, 1, 32'(20 + i), 0, 3'(i));
            cycle();
        end
        idle();
        fu_ready_in = 1;
        #2;
        rst_n_in = 0;
        model_clear();
        #1;
        chk("rst_full",  32'(full_out),        32'd0);
        chk("rst_empty", 32'(empty_out),       32'd1);
        chk("rst_issue", 32'(issue_valid_out), 32'd0);
        chk("rst_rval1", rval1_out,            32'd0);
        chk("rst_rval2", rval2_out,            32'd0);
        chk("rst_rob",   32'(rob_ix_out),      32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1;
        @(posedge clk_in);
        #1;
        cycle();
        chk("rst_no_stale", 32'(obs_iv), 32'd0);

        // Dispatch with both operands ready
        fu_ready_in = 1;
        disp(1, 32'd7, 0, 1, 32'hFFFF_FFFD, 0, 3'd5);
        cycle();
        chk("rdy_issue_c0", 32'(obs_iv), 32'd0);
        idle();
        cycle();
        chk("rdy_issue_c1", 32'(obs_iv), 32'd1);
        chk("rdy_rval1",    obs_r1,      32'd7);
        chk("rdy_rval2",    obs_r2,      32'hFFFF_FFFD);
        chk("rdy_rob",      32'(obs_rob), 32'd5);
        cycle();
        chk("rdy_empty_after", 32'(obs_empty), 32'd1);

        // Wait for operand 1 then wake up from the CDB
        disp(0, 32'd0, 3'd2, 1, 32'd4, 0, 3'd1);
        cycle();
        idle();
        cycle();
        chk("wake_c1", 32'(obs_iv), 32'd0);
        cycle();
        chk("wake_c2", 32'(obs_iv), 32'd0);
        cdb(3'd2, 32'd9);
        cycle();
`ifdef MUL_RS_WAKEUP_BYPASS_EN
        chk("wake_c3_issue", 32'(obs_iv), 32'd1);
        chk("wake_c3_rval1", obs_r1,      32'd9);
        chk("wake_c3_rval2", obs_r2,      32'd4);
`else
        chk("wake_c3_issue", 32'(obs_iv), 32'd0);
`endif
        idle();
        cycle();
`ifdef MUL_RS_WAKEUP_BYPASS_EN
        chk("wake_c4_issue", 32'(obs_iv), 32'd0);
`else
        chk("wake_c4_issue", 32'(obs_iv), 32'd1);
        chk("wake_c4_rval1", obs_r1,      32'd9);
        chk("wake_c4_rval2", obs_r2,      32'd4);
`endif

        // Same-cycle dispatch and CDB hit on both operands
        disp(0, 32'd0, 3'd6, 0, 32'd0, 3'd6, 3'd3);
        cdb(3'd6, 32'd11);
        cycle();
        idle();
        cycle();
        chk("samecyc_issue", 32'(obs_iv), 32'd1);
        chk("samecyc_rval1", obs_r1,      32'd11);
        chk("samecyc_rval2", obs_r2,      32'd11);
        chk("samecyc_rob",   32'(obs_rob), 32'd3);
        cycle();

        // Full boundary
        fu_ready_in = 0;
        for (int i = 0; i < 4; i++) begin
            disp(1, 32'(100 + i), 0, 1, 32'(i), 0, 3'(i));
            cycle();
        end
        disp(1, 32'd555, 0, 1, 32'd555, 0, 3'd7);
        cycle();
        chk("full_set", 32'(obs_full), 32'd1);
        idle();
        cycle();
        chk("full_5th_ignored", 32'(obs_full), 32'd1);
        fu_ready_in = 1;
        disp(1, 32'd300, 0, 1, 32'd300, 0, 3'd7);
        cycle();
        chk("full_rel_issue", 32'(obs_iv), 32'd1);
        chk("full_rel_rval1", obs_r1,      32'd100);
        chk("full_rel_rob",   32'(obs_rob), 32'd0);
        fu_ready_in = 0;
        idle();
        cycle();
        chk("full_cleared", 32'(obs_full), 32'd0);
        disp(1, 32'd200, 0, 1, 32'd201, 0, 3'd6);
        cycle();
        idle();
        fu_ready_in = 1;
        cycle();
        chk("slot0_reuse_issue", 32'(obs_iv), 32'd1);
        chk("slot0_reuse_rval1", obs_r1,      32'd200);
        chk("slot0_reuse_rob",   32'(obs_rob), 32'd6);
        repeat (4) cycle();
        chk("full_drained", 32'(obs_empty), 32'd1);

        // Flush precedence
        fu_ready_in = 0;
        disp(0, 0, 3'd1, 1, 32'd5, 0, 3'd1); cycle();
        disp(1, 32'd8, 0, 0, 0, 3'd1, 3'd2); cycle();
        disp(1, 32'd3, 0, 1, 32'd4, 0, 3'd4); cycle();
        idle();
        flush_in    = 1;
        fu_ready_in = 1;
        disp(1, 32'd1, 0, 1, 32'd2, 0, 3'd5);
        cdb(3'd1, 32'd66);
        cycle();
        idle();
        cycle();
        chk("flush_empty", 32'(obs_empty), 32'd1);
        chk("flush_issue", 32'(obs_iv),    32'd0);
        cdb(3'd1, 32'd77);
        cycle();
        chk("flush_late_cdb", 32'(obs_iv), 32'd0);
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                disp($urandom_range(0, 1) == 1, $urandom, 3'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom, 3'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1)
                cdb(3'($urandom_range(0, 3)), $urandom);
            fu_ready_in = ($urandom_range(0, 9) < 6);
            flush_in    = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
